axi_lite_reg_slave: RTL and testbench

//  AXI4-Lite slave backend: a bank of C_NUM_REG 32-bit read/write control registers,

---
 rtl/axi_lite_pkg.sv | 14 +
 rtl/axi_lite_reg_decode.sv | 24 ++
 rtl/axi_lite_reg_slave.sv | 201 ++++++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: response codes and FSM state types shared by the AXI4-Lite register slave.
//   RESP_*     : BRESP/RRESP encodings
//   w_state_e  : write channel states (W_IDLE accepting AW/W, W_RESP holding B)
//   r_state_e  : read channel states (R_IDLE accepting AR, R_DATA holding R)
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

endpackage

// File: rtl/axi_lite_reg_decode.sv
// axi_lite_reg_decode: combinational address decoder for the register window.
//   addr : byte address from AW or AR
//   idx  : word index from the window base (byte offset bits ignored)
//   resp : DECERR outside [BASE,HIGH], SLVERR for an unimplemented index, else OKAY
module axi_lite_reg_decode
    import axi_lite_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8800_0000,
    parameter logic [ADDR_W-1:0] HIGH    = 32'h8800_01FF,
    parameter int                NUM_REG = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [6:0]        idx,
    output logic [1:0]        resp
);

    always_comb begin
        idx  = 7'((addr - BASE) >> 2);
        resp = (addr < BASE || addr > HIGH)     ? RESP_DECERR :
               ({1'b0, idx} >= 8'(NUM_REG))    ? RESP_SLVERR : RESP_OKAY;
    end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite slave exposing C_NUM_REG read/write registers to user logic.
//   ACLK/ARESET        : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*    : write address, data and response channels
//   S_AXI_AR*/R*       : read address and data channels
//   USR_REG_OUT        : register k at bits [32k+31:32k]
//   USR_WR_PULSE       : bit k high for one cycle after a committed write to register k
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int                            C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_AXI_BASE_ADDR  = 32'h8800_0000,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_AXI_HIGH_ADDR  = 32'h8800_01FF,
    parameter int                            C_S_AXI_DATA_WIDTH = 32,
    parameter int                            C_NUM_REG          = 8
) (
    input  logic                                    ACLK,
    input  logic                                    ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
    input  logic [2:0]                              S_AXI_AWPROT,
    input  logic                                    S_AXI_AWVALID,
    output logic                                    S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
    input  logic                                    S_AXI_WVALID,
    output logic                                    S_AXI_WREADY,
    output logic [1:0]                              S_AXI_BRESP,
    output logic                                    S_AXI_BVALID,
    input  logic                                    S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
    input  logic [2:0]                              S_AXI_ARPROT,
    input  logic                                    S_AXI_ARVALID,
    output logic                                    S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]           S_AXI_RDATA,
    output logic [1:0]                              S_AXI_RRESP,
    output logic                                    S_AXI_RVALID,
    input  logic                                    S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*C_NUM_REG-1:0] USR_REG_OUT,
    output logic [C_NUM_REG-1:0]                    USR_WR_PULSE
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    logic [6:0] aw_dec_idx, ar_dec_idx;
    logic [1:0] aw_dec_resp, ar_dec_resp;

    axi_lite_reg_decode #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .BASE   (C_S_AXI_BASE_ADDR),
        .HIGH   (C_S_AXI_HIGH_ADDR),
        .NUM_REG(C_NUM_REG)
    ) u_aw_dec (
        .addr(S_AXI_AWADDR),
        .idx (aw_dec_idx),
        .resp(aw_dec_resp)
    );

    axi_lite_reg_decode #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH),
        .BASE   (C_S_AXI_BASE_ADDR),
        .HIGH   (C_S_AXI_HIGH_ADDR),
        .NUM_REG(C_NUM_REG)
    ) u_ar_dec (
        .addr(S_AXI_ARADDR),
        .idx (ar_dec_idx),
        .resp(ar_dec_resp)
    );

    w_state_e         w_state_q, w_state_d;
    r_state_e         r_state_q, r_state_d;
    logic             aw_full_q, aw_full_d;
    logic [6:0]       aw_idx_q, aw_idx_d;
    logic [1:0]       aw_resp_q, aw_resp_d;
    logic             w_full_q, w_full_d;
    logic [DW-1:0]    w_data_q, w_data_d;
    logic [NB-1:0]    w_strb_q, w_strb_d;
    logic             awready_q, awready_d;
    logic             wready_q, wready_d;
    logic             bvalid_q, bvalid_d;
    logic [1:0]       bresp_q, bresp_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic [1:0]       rresp_q, rresp_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [DW-1:0]    reg_q [C_NUM_REG];
    logic [DW-1:0]    reg_d [C_NUM_REG];
    logic [C_NUM_REG-1:0] pulse_q, pulse_d;

    logic          aw_hs, w_hs, ar_hs, commit, okay;
    logic [6:0]    cur_idx;
    logic [1:0]    cur_resp;
    logic [DW-1:0] cur_data, rd_word;
    logic [NB-1:0] cur_strb;

    // A live handshake bypasses its empty hold register so AW and W arriving
    // on the same edge commit immediately.
    always_comb begin
        aw_hs     = S_AXI_AWVALID && awready_q;
        w_hs      = S_AXI_WVALID && wready_q;
        cur_idx   = aw_full_q ? aw_idx_q : aw_dec_idx;
        cur_resp  = aw_full_q ? aw_resp_q : aw_dec_resp;
        cur_data  = w_full_q ? w_data_q : S_AXI_WDATA;
        cur_strb  = w_full_q ? w_strb_q : S_AXI_WSTRB;
        commit    = (w_state_q == W_IDLE) && (aw_full_q || aw_hs) && (w_full_q || w_hs);
        okay      = commit && (cur_resp == RESP_OKAY);
        aw_full_d = !commit && (aw_full_q || aw_hs);
        w_full_d  = !commit && (w_full_q || w_hs);
        aw_idx_d  = aw_hs ? aw_dec_idx : aw_idx_q;
        aw_resp_d = aw_hs ? aw_dec_resp : aw_resp_q;
        w_data_d  = w_hs ? S_AXI_WDATA : w_data_q;
        w_strb_d  = w_hs ? S_AXI_WSTRB : w_strb_q;
        w_state_d = commit ? W_RESP :
                    (w_state_q == W_RESP && S_AXI_BREADY) ? W_IDLE : w_state_q;
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = commit ? cur_resp : bresp_q;
        awready_d = (w_state_d == W_IDLE) && !aw_full_d;
        wready_d  = (w_state_d == W_IDLE) && !w_full_d;
        for (int k = 0; k < C_NUM_REG; k++) begin
            pulse_d[k] = okay && (cur_idx == 7'(k));
            reg_d[k]   = reg_q[k];
            for (int b = 0; b < NB; b++) begin
                if (pulse_d[k] && cur_strb[b]) reg_d[k][8*b +: 8] = cur_data[8*b +: 8];
            end
        end
    end

    // Reads sample reg_q, so a same-edge write is not visible (read-before-write).
    always_comb begin
        ar_hs     = S_AXI_ARVALID && arready_q;
        r_state_d = ar_hs ? R_DATA :
                    (r_state_q == R_DATA && S_AXI_RREADY) ? R_IDLE : r_state_q;
        rvalid_d  = (r_state_d == R_DATA);
        arready_d = (r_state_d == R_IDLE);
        rresp_d   = ar_hs ? ar_dec_resp : rresp_q;
        rd_word   = '0;
        for (int k = 0; k < C_NUM_REG; k++) begin
            if (ar_dec_idx == 7'(k)) rd_word = reg_q[k];
        end
        rdata_d   = !ar_hs ? rdata_q : (ar_dec_resp == RESP_OKAY) ? rd_word : '0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_resp_q <= RESP_OKAY;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            reg_q     <= '{default: '0};
            pulse_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            aw_resp_q <= aw_resp_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            reg_q     <= reg_d;
            pulse_q   <= pulse_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign USR_WR_PULSE  = pulse_q;

    for (genvar k = 0; k < C_NUM_REG; k++) begin : g_out
        assign USR_REG_OUT[DW*k +: DW] = reg_q[k];
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb_axi_lite_reg_slave: directed and randomized checks of axi_lite_reg_slave against a transaction-level model.
module tb_axi_lite_reg_slave;

    localparam logic [31:0] BASE = 32'h8800_0000;
    localparam logic [31:0] HIGH = 32'h8800_01FF;
    localparam int          NREG = 8;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b0;
    logic [31:0]  S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b1;
    logic [31:0]  S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b1;
    logic [255:0] USR_REG_OUT;
    logic [7:0]   USR_WR_PULSE;

    axi_lite_reg_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .USR_REG_OUT(USR_REG_OUT), .USR_WR_PULSE(USR_WR_PULSE)
    );

    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired or event unexpected", name);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t         wq[$];
    logic [31:0] rq[$];
    logic [31:0] m_reg [NREG];

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        if (a < BASE || a > HIGH) return 2'b11;
        if (int'((a - BASE) >> 2) >= NREG) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [255:0] flat();
        logic [255:0] f;
        f = '0;
        for (int k = 0; k < NREG; k++) f[32*k +: 32] = m_reg[k];
        return f;
    endfunction

    // ---------------- compare process ----------------
    int          cyc = 0;
    int          last_b = -1;
    int          last_r = -1;
    bit          b2b = 1'b0;
    logic        prev_b = 1'b0;
    logic        prev_r = 1'b0;
    logic [1:0]  lat_bresp = '0;
    logic [1:0]  lat_rresp = '0;
    logic [31:0] lat_rdata = '0;
    logic [7:0]  m_ep;
    wr_t         m_w;
    logic [31:0] m_a;
    int          m_i;

    always @(negedge ACLK) begin
        cyc++;
        if (ARESET) begin
            wq.delete();
            rq.delete();
            foreach (m_reg[k]) m_reg[k] = '0;
            prev_b = 1'b0;
            prev_r = 1'b0;
        end else begin
            chk("arready_vs_rvalid", S_AXI_ARREADY, !S_AXI_RVALID);
            // Reads are scored before writes so a same-edge write is not yet visible.
            if (prev_r) begin
                chk("r_hold", S_AXI_RVALID, !S_AXI_RREADY);
                if (S_AXI_RVALID) begin
                    chk("rdata_stable", S_AXI_RDATA, lat_rdata);
                    chk("rresp_stable", S_AXI_RRESP, lat_rresp);
                end
            end else if (S_AXI_RVALID) begin
                if (rq.size() == 0) fail_now("r_unexpected");
                else begin
                    m_a = rq.pop_front();
                    lat_rresp = exp_resp(m_a);
                    lat_rdata = (lat_rresp == 2'b00) ? m_reg[int'((m_a - BASE) >> 2)] : 32'h0;
                    chk("rresp", S_AXI_RRESP, lat_rresp);
                    chk("rdata", S_AXI_RDATA, lat_rdata);
                    if (b2b && last_r >= 0) chk("r_rate", cyc - last_r, 2);
                    last_r = cyc;
                end
            end
            m_ep = '0;
            if (prev_b) begin
                chk("b_hold", S_AXI_BVALID, !S_AXI_BREADY);
                if (S_AXI_BVALID) chk("bresp_stable", S_AXI_BRESP, lat_bresp);
            end else if (S_AXI_BVALID) begin
                if (wq.size() == 0) fail_now("b_unexpected");
                else begin
                    m_w = wq.pop_front();
                    lat_bresp = exp_resp(m_w.addr);
                    chk("bresp", S_AXI_BRESP, lat_bresp);
                    if (lat_bresp == 2'b00) begin
                        m_i = int'((m_w.addr - BASE) >> 2);
                        m_ep[m_i] = 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (m_w.strb[b]) m_reg[m_i][8*b +: 8] = m_w.data[8*b +: 8];
                    end
                    if (b2b && last_b >= 0) chk("b_rate", cyc - last_b, 2);
                    last_b = cyc;
                end
            end
            chk("wr_pulse", USR_WR_PULSE, m_ep);
            chk("reg_out", USR_REG_OUT, flat());
            if (S_AXI_BVALID) begin
                chk("awready_in_resp", S_AXI_AWREADY, 1'b0);
                chk("wready_in_resp", S_AXI_WREADY, 1'b0);
            end
            prev_b = S_AXI_BVALID;
            prev_r = S_AXI_RVALID;
        end
    end

    // ---------------- BREADY/RREADY driver ----------------
    int mode = 0;   // 0: both high, 1: random, 2: driven by the main sequence

    initial forever begin
        @(negedge ACLK);
        #1;
        if (mode == 1) begin
            S_AXI_BREADY = 1'($urandom_range(0, 1));
            S_AXI_RREADY = 1'($urandom_range(0, 1));
        end else if (mode == 0) begin
            S_AXI_BREADY = 1'b1;
            S_AXI_RREADY = 1'b1;
        end
    end

    // ---------------- channel drivers (called at a negedge) ----------------
    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        S_AXI_AWADDR = a;
        S_AXI_AWPROT = 3'($urandom);
        S_AXI_AWVALID = 1'b1;
        while (!S_AXI_AWREADY && n < 200) begin @(negedge ACLK); n++; end
        if (!S_AXI_AWREADY) fail_now("aw_timeout");
        else @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        S_AXI_WDATA = d;
        S_AXI_WSTRB = s;
        S_AXI_WVALID = 1'b1;
        while (!S_AXI_WREADY && n < 200) begin @(negedge ACLK); n++; end
        if (!S_AXI_WREADY) fail_now("w_timeout");
        else @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        int n = 0;
        rq.push_back(a);
        S_AXI_ARADDR = a;
        S_AXI_ARPROT = 3'($urandom);
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && n < 200) begin @(negedge ACLK); n++; end
        if (!S_AXI_ARREADY) fail_now("ar_timeout");
        else @(posedge ACLK);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        wr_t t;
        t.addr = a;
        t.data = d;
        t.strb = s;
        wq.push_back(t);
        fork
            begin repeat (aw_dly) @(negedge ACLK); send_aw(a); end
            begin repeat (w_dly) @(negedge ACLK); send_w(d, s); end
        join
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4));
        if (r == 1) return HIGH + 32'($urandom_range(1, 64));
        if (r == 2) return BASE + 32'(4 * $urandom_range(8, 127)) + 32'($urandom_range(0, 3));
        return BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        #2 ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_awready", S_AXI_AWREADY, 1'b1);
        chk("rst_wready", S_AXI_WREADY, 1'b1);
        chk("rst_arready", S_AXI_ARREADY, 1'b1);
        chk("rst_bvalid", S_AXI_BVALID, 1'b0);
        chk("rst_rvalid", S_AXI_RVALID, 1'b0);
        chk("rst_bresp", S_AXI_BRESP, 2'b00);
        chk("rst_rresp", S_AXI_RRESP, 2'b00);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_regs", USR_REG_OUT, 256'h0);

        // 1: reset while an AW is held waiting for its W
        send_aw(BASE + 32'h4);
        chk("aw_held_awready", S_AXI_AWREADY, 1'b0);
        chk("aw_held_wready", S_AXI_WREADY, 1'b1);
        #1 ARESET = 1'b1;
        #1;
        chk("midrst_bvalid", S_AXI_BVALID, 1'b0);
        chk("midrst_awready", S_AXI_AWREADY, 1'b1);
        chk("midrst_regs", USR_REG_OUT, 256'h0);
        repeat (2) @(negedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        begin
            wr_t t;
            t.addr = BASE;
            t.data = 32'hCAFE_F00D;
            t.strb = 4'hF;
            wq.push_back(t);
        end
        send_w(32'hCAFE_F00D, 4'hF);
        for (int i = 0; i < 3; i++) begin
            chk("dropped_aw_no_b", S_AXI_BVALID, 1'b0);
            @(negedge ACLK);
        end
        send_aw(BASE);
        chk("reg0_after_late_aw", USR_REG_OUT[31:0], 32'hCAFE_F00D);
        repeat (2) @(negedge ACLK);

        // 2: AW and W together
        do_write(32'h8800_0004, 32'hDEAD_BEEF, 4'hF, 0, 0);
        chk("t2_bvalid", S_AXI_BVALID, 1'b1);
        chk("t2_bresp", S_AXI_BRESP, 2'b00);
        chk("t2_pulse", USR_WR_PULSE, 8'h02);
        chk("t2_reg1", USR_REG_OUT[63:32], 32'hDEAD_BEEF);
        @(negedge ACLK);
        chk("t2_pulse_gone", USR_WR_PULSE, 8'h00);
        chk("t2_b_done", S_AXI_BVALID, 1'b0);
        repeat (2) @(negedge ACLK);

        // 3: W two cycles ahead of AW, partial strobes
        fork
            do_write(32'h8800_0008, 32'h1122_3344, 4'b0101, 2, 0);
            begin
                repeat (2) begin
                    @(negedge ACLK);
                    chk("t3_no_b_before_aw", S_AXI_BVALID, 1'b0);
                end
            end
        join
        chk("t3_bvalid", S_AXI_BVALID, 1'b1);
        chk("t3_reg2", USR_REG_OUT[95:64], 32'h0022_0044);
        repeat (3) @(negedge ACLK);

        // 4: SLVERR write, DECERR read
        do_write(32'h8800_0040, 32'h1234_5678, 4'hF, 0, 0);
        chk("t4_bresp", S_AXI_BRESP, 2'b10);
        chk("t4_no_pulse", USR_WR_PULSE, 8'h00);
        chk("t4_regs", USR_REG_OUT, {160'h0, 32'h0022_0044, 32'hDEAD_BEEF, 32'hCAFE_F00D});
        repeat (2) @(negedge ACLK);
        do_read(32'h8800_0200);
        chk("t4_rresp", S_AXI_RRESP, 2'b11);
        chk("t4_rdata", S_AXI_RDATA, 32'h0);
        repeat (2) @(negedge ACLK);

        // 5: read held off by RREADY for three cycles
        mode = 2;
        #1 S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        do_read(32'h8800_0004);
        for (int i = 0; i < 3; i++) begin
            chk("t5_rvalid", S_AXI_RVALID, 1'b1);
            chk("t5_rdata", S_AXI_RDATA, 32'hDEAD_BEEF);
            chk("t5_arready", S_AXI_ARREADY, 1'b0);
            if (i < 2) @(negedge ACLK);
        end
        #1 S_AXI_RREADY = 1'b1;
        mode = 0;
        @(negedge ACLK);
        chk("t5_released", S_AXI_RVALID, 1'b0);
        chk("t5_arready_back", S_AXI_ARREADY, 1'b1);
        repeat (2) @(negedge ACLK);

        // 6: back-to-back writes then reads at full rate
        last_b = -1;
        last_r = -1;
        b2b = 1'b1;
        for (int k = 0; k < NREG; k++) do_write(BASE + 32'(4 * k), $urandom, 4'hF, 0, 0);
        for (int k = 0; k < NREG; k++) do_read(BASE + 32'(4 * k));
        repeat (3) @(negedge ACLK);
        b2b = 1'b0;

        // randomized traffic with random handshake timing on all channels
        mode = 1;
        fork
            repeat (60) do_write(rand_addr(), $urandom, 4'($urandom),
                                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            repeat (60) begin
                repeat ($urandom_range(0, 2)) @(negedge ACLK);
                do_read(rand_addr());
            end
        join
        mode = 0;
        begin
            int n = 0;
            while ((wq.size() != 0 || rq.size() != 0) && n < 100) begin @(negedge ACLK); n++; end
            if (wq.size() != 0 || rq.size() != 0) fail_now("drain");
        end
        repeat (3) @(negedge ACLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
